// File: rtl/eth_tx_framer_pkg.sv
// Shared constants and state type for the Ethernet TX byte framer.
package eth_tx_framer_pkg;

  localparam int unsigned BYTE_LEN        = 8;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam int unsigned ETH_MIN_PAYLOAD = 60;
  localparam int unsigned PREAMBLE_LEN    = 7;
  localparam int unsigned LEN_W           = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IPG
  } tx_state_e;

endpackage

// File: rtl/eth_tx_framer_crc32_byte.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32.
module crc32_byte
  import eth_tx_framer_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] w_acc;

  // Bit-serial LSB-first division unrolled over the eight data bits.
  always_comb begin
    w_acc = i_crc ^ {24'h00_0000, i_byte};
    for (int unsigned i = 0; i < 8; i++) begin
      w_acc = w_acc[0] ? ((w_acc >> 1) ^ CRC32_POLY) : (w_acc >> 1);
    end
    o_crc = w_acc;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble/SFD, payload pull, zero pad, FCS, inter-packet gap.
module eth_tx_framer
  import eth_tx_framer_pkg::*;
#(
  parameter int unsigned MIN_PAYLOAD                = ETH_MIN_PAYLOAD,
  parameter int unsigned IPG_CYCLES                 = 52,
  parameter int unsigned RAM_READ_LATENCY           = 1,
  parameter int unsigned PACKET_BUFFER_READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                upstream_readclk,
  input  logic                inclk,
  input  logic [BYTE_LEN-1:0] in,
  input  logic                in_done,
  input  logic                downstream_rdy,
  output logic                outclk,
  output logic [BYTE_LEN-1:0] out,
  output logic                done
);

  // The handshake works with any upstream latency of at least one cycle.
  if (RAM_READ_LATENCY < 1 || PACKET_BUFFER_READ_LATENCY < 1) begin : g_bad_latency
    $error("eth_tx_framer: upstream read latency must be at least 1");
  end

  tx_state_e          r_state;
  logic               r_busy;
  logic [2:0]         r_cnt;
  logic [LEN_W-1:0]   r_len;
  logic [31:0]        r_crc;
  logic [7:0]         r_hold;
  logic               r_hold_full;
  logic               r_pending;
  logic               r_last_seen;
  logic [1:0]         r_fcs_idx;
  logic [31:0]        r_ipg_cnt;

  logic               w_emit_ok;
  logic [7:0]         w_out;
  logic [31:0]        w_fcs;
  logic [7:0]         w_crc_byte;
  logic [31:0]        w_crc_next;
  logic [LEN_W-1:0]   w_len_next;
  logic               w_prefetch;

  crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_byte (w_crc_byte),
    .o_crc  (w_crc_next)
  );

  assign w_fcs      = ~r_crc;
  assign w_crc_byte = (r_state == ST_PAD) ? 8'h00 : r_hold;
  assign w_len_next = (r_len == '1) ? r_len : r_len + 1'b1;
  assign w_prefetch = (r_state == ST_PRE || r_state == ST_SFD || r_state == ST_DATA);

  // Output byte mux and per-state emit qualification.
  always_comb begin
    w_emit_ok = 1'b0;
    w_out     = '0;
    unique case (r_state)
      ST_PRE:  begin w_emit_ok = 1'b1;        w_out = PREAMBLE_BYTE; end
      ST_SFD:  begin w_emit_ok = 1'b1;        w_out = SFD_BYTE;      end
      ST_DATA: begin w_emit_ok = r_hold_full; w_out = r_hold;        end
      ST_PAD:  begin w_emit_ok = 1'b1;        w_out = 8'h00;         end
      ST_FCS: begin
        w_emit_ok = 1'b1;
        unique case (r_fcs_idx)
          2'd0:    w_out = w_fcs[7:0];
          2'd1:    w_out = w_fcs[15:8];
          2'd2:    w_out = w_fcs[23:16];
          default: w_out = w_fcs[31:24];
        endcase
      end
      default: begin w_emit_ok = 1'b0; w_out = '0; end
    endcase
  end

  assign outclk           = w_emit_ok & downstream_rdy;
  assign out              = w_out;
  assign done             = outclk & (r_state == ST_FCS) & (r_fcs_idx == 2'd3);
  assign busy             = r_busy;
  assign upstream_readclk = w_prefetch & ~r_hold_full & ~r_pending & ~r_last_seen;

  // Frame sequencer plus hold-register prefetch; an emission empties the hold
  // register before a same-cycle upstream load refills it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_crc       <= CRC32_INIT;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_pending   <= 1'b0;
      r_last_seen <= 1'b0;
      r_fcs_idx   <= '0;
      r_ipg_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_PRE;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_len       <= '0;
            r_crc       <= CRC32_INIT;
            r_fcs_idx   <= '0;
            r_hold_full <= 1'b0;
            r_pending   <= 1'b0;
            r_last_seen <= 1'b0;
          end
        end
        ST_PRE: begin
          if (outclk) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == 3'(PREAMBLE_LEN - 1)) r_state <= ST_SFD;
          end
        end
        ST_SFD: begin
          if (outclk) r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (outclk) begin
            r_hold_full <= 1'b0;
            r_crc       <= w_crc_next;
            r_len       <= w_len_next;
            if (r_last_seen) begin
              r_state <= (32'(w_len_next) < MIN_PAYLOAD) ? ST_PAD : ST_FCS;
            end
          end
        end
        ST_PAD: begin
          if (outclk) begin
            r_crc <= w_crc_next;
            r_len <= w_len_next;
            if (32'(w_len_next) >= MIN_PAYLOAD) r_state <= ST_FCS;
          end
        end
        ST_FCS: begin
          if (outclk) begin
            r_fcs_idx <= r_fcs_idx + 1'b1;
            if (r_fcs_idx == 2'd3) begin
              r_state   <= ST_IPG;
              r_ipg_cnt <= 32'd1;
            end
          end
        end
        ST_IPG: begin
          if (r_ipg_cnt >= IPG_CYCLES) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ipg_cnt <= r_ipg_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (upstream_readclk) r_pending <= 1'b1;
      if (inclk && r_pending) begin
        r_pending   <= 1'b0;
        r_hold      <= in;
        r_hold_full <= 1'b1;
        r_last_seen <= in_done;
      end
    end
  end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Byte-stream framer for the Ethernet TX path. It sits between the packet-buffer reader (stream_from_memory) and the byte-to-dibit serializer (bytes_to_dibits_coord_buf).
- On start, it emits 7×0x55 preamble and 0xD5 SFD, then forwards payload bytes pulled from upstream on demand.
- It zero-pads the payload to the minimum length, appends the CRC-32 FCS LSB-first, then holds off the next frame for an inter-packet gap.
- It owns the upstream read handshake and honours downstream readiness on every byte.

Parameters:
- MIN_PAYLOAD, 60: minimum bytes (payload + pad) before FCS; 0 disables padding.
- IPG_CYCLES, 52: clk cycles held busy after the last FCS byte. This is 48 gap cycles plus 4 serializer drain cycles.
- RAM_READ_LATENCY, PACKET_BUFFER_READ_LATENCY: informational only. The handshake tolerates any upstream latency ≥1.

Ports:
- clk  in  1  system clock (50 MHz RMII domain)
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  one-cycle pulse that begins a frame; ignored while busy
- busy  out  1  high from the cycle after an accepted start until the IPG expires
- upstream_readclk  out  1  one-cycle request for the next payload byte
- inclk  in  1  upstream byte valid
- in  in  BYTE_LEN  upstream byte
- in_done  in  1  qualifies inclk; marks the last payload byte
- downstream_rdy  in  1  serializer can accept a byte this cycle
- outclk  out  1  byte valid to downstream (combinational: emitting state && downstream_rdy)
- out  out  BYTE_LEN  byte to downstream
- done  out  1  high with outclk on the final FCS byte

Behaviour:
- Reset: state=IDLE, busy=0, outclk=0, done=0, upstream_readclk=0.
  - The hold register is emptied, the pending flag cleared, and the counters zeroed.
  - A mid-frame reset aborts immediately with no further bytes; upstream must be reset alongside.
- States: IDLE → PRE → SFD → DATA → PAD → FCS → IPG → IDLE.
- IDLE: a start pulse moves to PRE next cycle with busy=1. start is ignored in every other state.
- PRE: out=0x55. Each outclk increments cnt; after the 7th byte → SFD.
- SFD: out=0xD5. On outclk → DATA.
- Prefetch during PRE, SFD and DATA:
  - upstream_readclk=1 when the hold register is empty, no request is pending, and the last byte has not yet been received.
  - The request sets pending. inclk clears pending, loads the hold register, and latches in_done as last_seen.
  - At most one request is outstanding.
  - inclk with no pending request is ignored.
- DATA:
  - Emits the hold register when it is full and downstream_rdy=1; emitting empties the register.
  - Each emitted byte feeds the CRC and increments len (11-bit, saturating at 2047).
  - If the hold register is empty, outclk=0 and the stream stalls without timeout.
  - After the last_seen byte is emitted: → PAD if len<MIN_PAYLOAD, else → FCS.
- PAD: out=0x00, included in the CRC and len. → FCS when len reaches MIN_PAYLOAD.
- CRC:
  - IEEE 802.3 reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at start.
  - Covers payload+pad only (not preamble/SFD).
  - The FCS is ~crc, sent as bytes [7:0], [15:8], [23:16], [31:24].
- FCS: byte index 0..3. done=outclk on index 3. → IPG.
- IPG: counts IPG_CYCLES clk cycles regardless of downstream_rdy, then → IDLE with busy=0 the following cycle.
- Downstream stall: a stall in any emitting state holds the state and out stable. downstream_rdy toggling never duplicates or drops bytes.
- Simultaneous inclk and emission in the same cycle: legal only if the register was emptied this cycle; the emission empties it first, then the load fills it.
- A 1-byte payload is legal. A zero-length payload is not permitted; upstream guarantees at least one byte.

Decomposition:
- Shared params.vh provides BYTE_LEN, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC32_POLY, CRC32_INIT, ETH_MIN_PAYLOAD.
- Sub-module crc32_byte: a combinational next-CRC function of (crc[31:0], byte[7:0]). The CRC register stays in eth_tx_framer.

Test Plan:
- MIN_PAYLOAD=0, payload "123456789" (0x31..0x39), downstream_rdy=1 → 0x55×7, D5, 31..39, 26 39 F4 CB; done on CB; busy low 52 cycles later.
- Default params, 1-byte payload 0xAB → 8 preamble/SFD bytes, AB, 59×00, 4 FCS bytes matching the software CRC; 72 outclk pulses total.
- Upstream latency 3 and downstream_rdy asserted every 4th cycle, 64-byte payload → byte order intact, no pad, exactly one outstanding request at any time.
- start pulsed during DATA and again during IPG → ignored; no second frame until busy=0; a start one cycle after busy falls is accepted.
- Reset asserted mid-DATA (byte 10), released, new start → outputs 0 during reset; next frame begins with a clean preamble and correct CRC.
- Random downstream_rdy over a 1500-byte payload → captured stream CRC checks with residue 0xDEBB20E3.
